// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode constants, control encodings and decoded-control struct
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_SLL   = 5'b00010;
  localparam logic [4:0] ALU_SLT   = 5'b00100;
  localparam logic [4:0] ALU_SLTU  = 5'b00110;
  localparam logic [4:0] ALU_XOR   = 5'b01000;
  localparam logic [4:0] ALU_LUI_B = 5'b01001;
  localparam logic [4:0] ALU_SRL   = 5'b01010;
  localparam logic [4:0] ALU_SRA   = 5'b01011;
  localparam logic [4:0] ALU_OR    = 5'b01100;
  localparam logic [4:0] ALU_AND   = 5'b01110;

  typedef enum logic [1:0] {
    BSEL_RS2  = 2'b00,
    BSEL_IMM  = 2'b01,
    BSEL_FOUR = 2'b10
  } bsel_e;

  typedef enum logic [2:0] {
    BW_NONE = 3'b000,
    BW_BEQ  = 3'b010,
    BW_BNE  = 3'b011,
    BW_BLTU = 3'b100,
    BW_BGEU = 3'b101,
    BW_BLT  = 3'b110,
    BW_BGE  = 3'b111
  } branch_e;

  typedef struct packed {
    logic       alu_a_sel;
    bsel_e      alu_b_sel;
    logic       pc_adder_a_sel;
    logic       rd_we;
    logic       mem_we;
    logic       rd_input_sel;
    logic [4:0] alu_op;
    logic [2:0] mem_op;
    branch_e    branch_way;
    logic       word;
    logic       illegal;
  } ctrl_t;

  // The base ALU codes are laid out so that func3 maps straight into bits [3:1].
  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    return {1'b0, f3, 1'b0};
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - pure combinational RV32/64 I(+M) control decode
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic       word;
  logic       shamt6;
  logic       shl_ok;
  logic       shr_ok;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    ctrl   = '0;
    legal  = 1'b0;
    word   = (opc == OPC_OP_IMM_32) || (opc == OPC_OP_32);
    // Only full-width immediate shifts on RV64 own shamt bit 5 (inst[25]).
    shamt6 = IS64 && !word;
    shl_ok = shamt6 ? (f7[6:1] == 6'b000000) : (f7 == 7'b0000000);
    shr_ok = shl_ok || (shamt6 ? (f7[6:1] == 6'b010000) : (f7 == 7'b0100000));
    case (opc)
      OPC_LUI: begin
        legal = 1'b1;
        ctrl.alu_b_sel = BSEL_IMM;
        ctrl.alu_op    = ALU_LUI_B;
        ctrl.rd_we     = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = BSEL_IMM;
        ctrl.rd_we     = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        legal = (opc == OPC_JAL) || (f3 == 3'b000);
        ctrl.alu_a_sel      = 1'b1;
        ctrl.alu_b_sel      = BSEL_FOUR;
        ctrl.pc_adder_a_sel = (opc == OPC_JALR);
        ctrl.rd_we          = 1'b1;
      end
      OPC_BRANCH: begin
        legal = 1'b1;
        ctrl.alu_b_sel = BSEL_RS2;
        ctrl.alu_op    = ALU_SLT;
        case (f3)
          3'b000:  ctrl.branch_way = BW_BEQ;
          3'b001:  ctrl.branch_way = BW_BNE;
          3'b100:  ctrl.branch_way = BW_BLT;
          3'b101:  ctrl.branch_way = BW_BGE;
          3'b110:  ctrl.branch_way = BW_BLTU;
          3'b111:  ctrl.branch_way = BW_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b111) && (IS64 || ((f3 != 3'b011) && (f3 != 3'b110)));
        ctrl.alu_b_sel    = BSEL_IMM;
        ctrl.rd_we        = 1'b1;
        ctrl.rd_input_sel = 1'b1;
        ctrl.mem_op       = f3;
      end
      OPC_STORE: begin
        legal = !f3[2] && (IS64 || (f3 != 3'b011));
        ctrl.alu_b_sel = BSEL_IMM;
        ctrl.mem_we    = 1'b1;
        ctrl.mem_op    = f3;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        ctrl.alu_b_sel = BSEL_IMM;
        ctrl.rd_we     = 1'b1;
        ctrl.word      = word;
        ctrl.alu_op    = alu_base(f3);
        case (f3)
          3'b000: legal = 1'b1;
          3'b001: legal = shl_ok;
          3'b101: begin
            legal = shr_ok;
            if (f7[5]) ctrl.alu_op = ALU_SRA;
          end
          default: legal = !word;
        endcase
      end
      OPC_OP, OPC_OP_32: begin
        ctrl.alu_b_sel = BSEL_RS2;
        ctrl.rd_we     = 1'b1;
        ctrl.word      = word;
        case (f7)
          7'b0000000: begin
            legal = !word || (f3 inside {3'b000, 3'b001, 3'b101});
            ctrl.alu_op = alu_base(f3);
          end
          7'b0100000: begin
            legal = (f3 == 3'b000) || (f3 == 3'b101);
            ctrl.alu_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
          end
          7'b0000001: begin
            legal = (HAS_M != 0) && (!word || !(f3 inside {3'b001, 3'b010, 3'b011}));
            ctrl.alu_op = {2'b10, f3};
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (word && !IS64) legal = 1'b0;
    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered decode stage with main register and one-entry skid
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_aluASel,
  output logic [1:0]      out_aluBSel,
  output logic            out_pcAdderASel,
  output logic            out_rdWriteEnable,
  output logic            out_memWriteEnable,
  output logic            out_rdInputSel,
  output logic [4:0]      out_aluOP,
  output logic [2:0]      out_memOP,
  output logic [2:0]      out_branchWay,
  output logic            out_word,
  output logic            out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } entry_t;

  ctrl_t      dec_ctrl;
  entry_t     new_e;
  entry_t     main_q;
  entry_t     skid_q;
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       accept;
  logic       handover;
  logic       load_main;
  logic       main_from_skid;
  logic       load_skid;

  ctrl_decode_comb #(.XLEN(XLEN), .HAS_M(HAS_M)) u_decode (
    .inst (in_inst),
    .ctrl (dec_ctrl)
  );

  always_comb begin
    new_e.ctrl = dec_ctrl;
    new_e.pc   = in_pc;
    new_e.rd   = in_inst[11:7];
    new_e.rs1  = in_inst[19:15];
    new_e.rs2  = in_inst[24:20];
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign handover  = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
        ST_ONE: begin
          // Accept with handover just replaces main; accept alone parks in the skid.
          if (accept && handover) load_main = 1'b1;
          else if (accept) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (handover) state_d = ST_EMPTY;
        end
        ST_TWO: if (handover) begin
          state_d        = ST_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != ST_TWO);
      if (load_main) main_q <= main_from_skid ? skid_q : new_e;
      if (load_skid) skid_q <= new_e;
    end
  end

  assign out_pc             = main_q.pc;
  assign out_rd             = main_q.rd;
  assign out_rs1            = main_q.rs1;
  assign out_rs2            = main_q.rs2;
  assign out_aluASel        = main_q.ctrl.alu_a_sel;
  assign out_aluBSel        = main_q.ctrl.alu_b_sel;
  assign out_pcAdderASel    = main_q.ctrl.pc_adder_a_sel;
  assign out_rdWriteEnable  = main_q.ctrl.rd_we;
  assign out_memWriteEnable = main_q.ctrl.mem_we;
  assign out_rdInputSel     = main_q.ctrl.rd_input_sel;
  assign out_aluOP          = main_q.ctrl.alu_op;
  assign out_memOP          = main_q.ctrl.mem_op;
  assign out_branchWay      = main_q.ctrl.branch_way;
  assign out_word           = main_q.ctrl.word;
  assign out_illegal        = main_q.ctrl.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - bench running a 32-bit/no-M and a 64-bit/M decode stage side by side
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic       a_sel;
    logic [1:0] b_sel;
    logic       pc_sel;
    logic       rd_we;
    logic       mem_we;
    logic       rd_in;
    logic [4:0] op;
    logic [2:0] mem_op;
    logic [2:0] bw;
    logic       word;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        o_valid [2];
  logic        o_ready [2];
  logic [63:0] o_pc    [2];
  logic [4:0]  o_rd    [2];
  logic [4:0]  o_rs1   [2];
  logic [4:0]  o_rs2   [2];
  exp_t        got     [2];

  item_t       q[$];
  bit          m_acc;
  bit          jitter;
  int          cyc;
  int          checks;
  int          errors;
  logic [31:0] tab[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int XL = (g == 0) ? 32 : 64;
    logic [XL-1:0] pc_o;
    logic          ov, ir, a_sel, pc_sel, rd_we, mem_we, rd_in, word, ill;
    logic [1:0]    b_sel;
    logic [4:0]    op, rd, rs1, rs2;
    logic [2:0]    mem_op, bw;

    ctrl_decode_stage #(.XLEN(XL), .HAS_M(g)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir), .in_inst(in_inst), .in_pc(in_pc[XL-1:0]),
      .out_valid(ov), .out_ready(out_ready), .out_pc(pc_o),
      .out_rd(rd), .out_rs1(rs1), .out_rs2(rs2),
      .out_aluASel(a_sel), .out_aluBSel(b_sel), .out_pcAdderASel(pc_sel),
      .out_rdWriteEnable(rd_we), .out_memWriteEnable(mem_we), .out_rdInputSel(rd_in),
      .out_aluOP(op), .out_memOP(mem_op), .out_branchWay(bw),
      .out_word(word), .out_illegal(ill)
    );

    assign o_valid[g] = ov;
    assign o_ready[g] = ir;
    assign o_pc[g]    = 64'(pc_o);
    assign o_rd[g]    = rd;
    assign o_rs1[g]   = rs1;
    assign o_rs2[g]   = rs2;
    assign got[g]     = {a_sel, b_sel, pc_sel, rd_we, mem_we, rd_in, op, mem_op, bw, word, ill};
  end

  // Reference decode: legality from the instruction tables, then attributes by instruction class.
  function automatic exp_t ref_dec(logic [31:0] i, bit x64, bit hm);
    exp_t        e;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [2:0]  bw_tab [8];
    bit          legal, is_m, regop, arith;
    bw_tab = '{3'b010, 3'b011, 3'b000, 3'b000, 3'b110, 3'b111, 3'b100, 3'b101};
    e     = '0;
    opc   = i[6:0];
    f3    = i[14:12];
    f7    = i[31:25];
    is_m  = (f7 == 7'h01);
    regop = (opc == 7'h33) || (opc == 7'h3B);
    arith = regop || (opc == 7'h13) || (opc == 7'h1B);
    case (opc)
      7'h37, 7'h17, 7'h6F: legal = 1;
      7'h67: legal = (f3 == 3'd0);
      7'h63: legal = (f3 != 3'd2) && (f3 != 3'd3);
      7'h03: legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (x64 && (f3 inside {3'd3, 3'd6}));
      7'h23: legal = (f3 <= 3'd2) || (x64 && f3 == 3'd3);
      7'h13: begin
        if (f3 == 3'd1)      legal = x64 ? (i[31:26] == 6'h00) : (f7 == 7'h00);
        else if (f3 == 3'd5) legal = x64 ? (i[31:26] inside {6'h00, 6'h10}) : (f7 inside {7'h00, 7'h20});
        else                 legal = 1;
      end
      7'h33: legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) || (is_m && hm);
      7'h1B: legal = x64 && ((f3 == 3'd0) || (f3 == 3'd1 && f7 == 7'h00) ||
                             (f3 == 3'd5 && (f7 inside {7'h00, 7'h20})));
      7'h3B: legal = x64 && ((f7 == 7'h00 && (f3 inside {3'd0, 3'd1, 3'd5})) ||
                             (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) ||
                             (is_m && hm && (f3 inside {3'd0, 3'd4, 3'd5, 3'd6, 3'd7})));
      default: legal = 0;
    endcase
    if (!legal) begin
      e.ill = 1'b1;
      return e;
    end
    e.a_sel  = (opc inside {7'h17, 7'h6F, 7'h67});
    e.b_sel  = (opc inside {7'h6F, 7'h67}) ? 2'b10 : (regop || opc == 7'h63) ? 2'b00 : 2'b01;
    e.pc_sel = (opc == 7'h67);
    e.rd_we  = !(opc inside {7'h63, 7'h23});
    e.mem_we = (opc == 7'h23);
    e.rd_in  = (opc == 7'h03);
    e.mem_op = (opc inside {7'h03, 7'h23}) ? f3 : 3'b000;
    e.word   = (opc inside {7'h1B, 7'h3B});
    e.bw     = (opc == 7'h63) ? bw_tab[f3] : 3'b000;
    if (opc == 7'h37)                         e.op = 5'b01001;
    else if (opc == 7'h63)                    e.op = 5'b00100;
    else if (regop && is_m)                   e.op = {2'b10, f3};
    else if (regop && f3 == 3'd0 && i[30])    e.op = 5'b00001;
    else if (arith && f3 == 3'd5 && i[30])    e.op = 5'b01011;
    else if (arith)                           e.op = {1'b0, f3, 1'b0};
    else                                      e.op = 5'b00000;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    int n;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    n = 0;
    do begin
      if (jitter) begin
        cyc++;
        out_ready = (cyc % 4 != 1);
      end
      tick();
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: inst %h not accepted after %0d cycles", inst, n);
    end
  endtask

  task automatic hold(input logic [31:0] inst, input logic [63:0] pc);
    out_ready = 1'b0;
    send(inst, pc);
    in_valid = 1'b0;
  endtask

  // Flow model: a queue of at most two outstanding instructions.
  always @(posedge clk) begin
    bit acc, hov;
    m_acc = 0;
    if (rst || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      hov = (q.size() > 0) && out_ready;
      if (hov) void'(q.pop_front());
      if (acc) q.push_back('{inst: in_inst, pc: in_pc});
      m_acc = acc;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("out_valid[%0d]", g), 64'(o_valid[g]), 64'(q.size() > 0));
      chk($sformatf("in_ready[%0d]", g), 64'(o_ready[g]), 64'(q.size() < 2));
      if (q.size() > 0) begin
        e = ref_dec(q[0].inst, g == 1, g == 1);
        chk($sformatf("out_pc[%0d]", g), o_pc[g], (g == 0) ? {32'b0, q[0].pc[31:0]} : q[0].pc);
        chk($sformatf("regs[%0d]", g), 64'({o_rd[g], o_rs1[g], o_rs2[g]}),
            64'({q[0].inst[11:7], q[0].inst[19:15], q[0].inst[24:20]}));
        chk($sformatf("ctrl[%0d] inst %h", g, q[0].inst), 64'(got[g]), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; jitter = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 64'h0;
    tab = '{32'h123452B7, 32'h00001197, 32'h008000EF, 32'h000280E7, 32'h000290E7,
            32'h00208463, 32'h00209463, 32'h0020A463, 32'h0020C463, 32'h0020D463,
            32'h00812303, 32'h00813303, 32'h00816303, 32'h00814303, 32'h00817303,
            32'h00612223, 32'h00613223, 32'h00614223, 32'h02109093, 32'h4030D093,
            32'h0030D093, 32'h402081B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020B1B3,
            32'h402091B3, 32'h002081BB, 32'h4020D1BB, 32'h022081BB, 32'h022091BB,
            32'h0220C1B3, 32'h4030D09B, 32'h0000000F, 32'h00000073, 32'h00000000};
    tick(); tick();
    for (int g = 0; g < 2; g++) begin
      chk("rst out_valid", 64'(o_valid[g]), 64'd0);
      chk("rst in_ready", 64'(o_ready[g]), 64'd1);
      chk("rst out_pc", o_pc[g], 64'd0);
      chk("rst ctrl", 64'(got[g]), 64'd0);
      chk("rst out_rd", 64'(o_rd[g]), 64'd0);
    end
    rst = 1'b0;
    tick();

    // addi x1,x0,5 streamed with out_ready high
    send(32'h00500093, 64'h0000_0001_0000_0100);
    in_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("addi out_valid", 64'(o_valid[g]), 64'd1);
      chk("addi aluOP", 64'(got[g].op), 64'b00000);
      chk("addi aluBSel", 64'(got[g].b_sel), 64'b01);
      chk("addi rdWE", 64'(got[g].rd_we), 64'd1);
      chk("addi rd", 64'(o_rd[g]), 64'd1);
    end
    tick(); tick();

    // three back-to-back with downstream stalled
    out_ready = 1'b0;
    send(32'h00500093, 64'h10);
    send(32'h402081B3, 64'h14);
    for (int g = 0; g < 2; g++) chk("b2b in_ready after 2nd", 64'(o_ready[g]), 64'd0);
    in_inst = 32'h0020E1B3; in_pc = 64'h18;
    tick(); tick();
    for (int g = 0; g < 2; g++) begin
      chk("b2b stalled pc", o_pc[g], 64'h10);
      chk("b2b in_ready held", 64'(o_ready[g]), 64'd0);
    end
    out_ready = 1'b1;
    send(32'h0020E1B3, 64'h18);
    in_valid = 1'b0;
    repeat (4) tick();

    hold(32'h00B56463, 64'h20);
    for (int g = 0; g < 2; g++) begin
      chk("bltu branchWay", 64'(got[g].bw), 64'b100);
      chk("bltu rdWE", 64'(got[g].rd_we), 64'd0);
    end
    out_ready = 1'b1; tick();
    hold(32'h00B57463, 64'h24);
    for (int g = 0; g < 2; g++) chk("bgeu branchWay", 64'(got[g].bw), 64'b101);
    out_ready = 1'b1; tick();

    hold(32'h02B50533, 64'h28);
    chk("mul noM illegal", 64'(got[0].ill), 64'd1);
    chk("mul noM rdWE", 64'(got[0].rd_we), 64'd0);
    chk("mul noM memWE", 64'(got[0].mem_we), 64'd0);
    chk("mul M aluOP", 64'(got[1].op), 64'b10000);
    chk("mul M illegal", 64'(got[1].ill), 64'd0);
    out_ready = 1'b1; tick();

    hold(32'h0015051B, 64'h2C);
    chk("addiw rv32 illegal", 64'(got[0].ill), 64'd1);
    chk("addiw rv64 word", 64'(got[1].word), 64'd1);
    chk("addiw rv64 aluOP", 64'(got[1].op), 64'b00000);
    chk("addiw rv64 illegal", 64'(got[1].ill), 64'd0);
    out_ready = 1'b1; tick();

    // flush while both entries are held, with a competing accept
    out_ready = 1'b0;
    send(32'h00500093, 64'h30);
    send(32'h00500093, 64'h34);
    in_inst = 32'h0020B1B3; in_pc = 64'h38; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("flush out_valid", 64'(o_valid[g]), 64'd0);
      chk("flush in_ready", 64'(o_ready[g]), 64'd1);
    end
    tick();
    for (int g = 0; g < 2; g++) chk("flush drops accept", 64'(o_valid[g]), 64'd0);
    out_ready = 1'b1;

    // reset in the middle of operation beats flush and handshake
    out_ready = 1'b0;
    send(32'h123452B7, 64'hFFFF_0000_0000_0040);
    send(32'h00813303, 64'h44);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("midrst out_valid", 64'(o_valid[g]), 64'd0);
      chk("midrst in_ready", 64'(o_ready[g]), 64'd1);
      chk("midrst out_pc", o_pc[g], 64'd0);
      chk("midrst ctrl", 64'(got[g]), 64'd0);
    end
    out_ready = 1'b1;
    tick();

    // instruction sweep with a stuttering downstream
    jitter = 1;
    for (int k = 0; k < tab.size(); k++) begin
      send(tab[k], {32'hA5A5_0000 ^ 32'(k), 32'h1000 + 32'(4 * k)});
      if (k % 4 == 3) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    jitter = 0;
    out_ready = 1'b1;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
